// File: rtl/multi_signal_filter.sv
// Multi-channel edge qualifier: synchronises CH inputs and accepts a level change only after it holds for RISE_TIME/FALL_TIME timer ticks.
// Optional per-channel saturating glitch counters are built when MULTI_SIGNAL_FILTER_GLITCH_CNT_EN is defined.
module multi_signal_filter #(
   parameter int   CH        = 4,
   parameter int   TW        = 8,
   parameter int   RISE_TIME = 200,
   parameter int   FALL_TIME = 200,
   parameter logic INIT      = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CH-1:0]   sin,
   input  logic [TW-1:0]   timer_600n,
   input  logic            cnt_clr,
   output logic [CH-1:0]   sout,
   output logic [CH-1:0]   glitch,
   output logic            busy,
   output logic [8*CH-1:0] glitch_cnt
);

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   localparam logic [TW-1:0] RISE_T = TW'(RISE_TIME);
   localparam logic [TW-1:0] FALL_T = TW'(FALL_TIME);

   logic [CH-1:0] s0_reg;
   logic [CH-1:0] s1_reg;
   logic [CH-1:0] s2_reg;
   logic [CH-1:0] edge_det;
   logic [CH-1:0] pend_next;
   logic [CH-1:0] glitch_next;
   logic          busy_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_reg <= {CH{INIT}};
         s1_reg <= {CH{INIT}};
         s2_reg <= {CH{INIT}};
      end else begin
         s0_reg <= sin;
         s1_reg <= s0_reg;
         s2_reg <= s1_reg;
      end
   end

   assign edge_det = s1_reg ^ s2_reg;

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         state_t          state_reg, state_next;
         logic [TW-1:0]   tgt_reg, tgt_next;
         logic            lvl_reg, lvl_next;
         logic            sout_reg, sout_next;
         logic            glitch_reg, glitch_nx;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_reg  <= IDLE;
               tgt_reg    <= '0;
               lvl_reg    <= INIT;
               sout_reg   <= INIT;
               glitch_reg <= 1'b0;
            end else begin
               state_reg  <= state_next;
               tgt_reg    <= tgt_next;
               lvl_reg    <= lvl_next;
               sout_reg   <= sout_next;
               glitch_reg <= glitch_nx;
            end
         end

         // Any edge while pending is a return to the sout level, so it always aborts, even on the match cycle.
         always_comb begin
            state_next = state_reg;
            tgt_next   = tgt_reg;
            lvl_next   = lvl_reg;
            sout_next  = sout_reg;
            glitch_nx  = 1'b0;
            case (state_reg)
               IDLE: begin
                  if (edge_det[gi]) begin
                     state_next = PEND;
                     lvl_next   = s1_reg[gi];
                     tgt_next   = timer_600n + (s1_reg[gi] ? RISE_T : FALL_T);
                  end
               end
               PEND: begin
                  if (edge_det[gi]) begin
                     state_next = IDLE;
                     glitch_nx  = 1'b1;
                  end else if (timer_600n == tgt_reg) begin
                     state_next = IDLE;
                     sout_next  = lvl_reg;
                  end
               end
               default: state_next = IDLE;
            endcase
         end

         assign pend_next[gi]   = (state_next == PEND);
         assign glitch_next[gi] = glitch_nx;
         assign sout[gi]        = sout_reg;
         assign glitch[gi]      = glitch_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_reg <= 1'b0;
      end else begin
         busy_reg <= |pend_next;
      end
   end

   assign busy = busy_reg;

`ifdef MULTI_SIGNAL_FILTER_GLITCH_CNT_EN
   generate
      for (gi = 0; gi < CH; gi++) begin : g_cnt
         logic [7:0] cnt_reg;

         // Clear takes priority over an increment on the same edge.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg <= '0;
            end else if (cnt_clr) begin
               cnt_reg <= '0;
            end else if (glitch_next[gi] && (cnt_reg != 8'hFF)) begin
               cnt_reg <= cnt_reg + 8'd1;
            end
         end

         assign glitch_cnt[8*gi +: 8] = cnt_reg;
      end
   endgenerate
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign glitch_cnt     = '0;
`endif

endmodule

// File: tb/tb_multi_signal_filter.sv
// Scoreboard bench for multi_signal_filter: expected sout changes and glitch pulses are queued per stimulus and matched by a monitor.
module tb_multi_signal_filter;
   localparam int CH   = 4;
   localparam int TW   = 8;
   localparam int RISE = 200;
   localparam int FALL = 60;
   localparam int STEP = 4;
   localparam int OFF  = 37;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [CH-1:0]   sin = '0;
   logic [TW-1:0]   timer_600n;
   logic            cnt_clr = 1'b0;
   logic [CH-1:0]   sout;
   logic [CH-1:0]   glitch;
   logic            busy;
   logic [8*CH-1:0] glitch_cnt;

   always #5 clk = ~clk;

   multi_signal_filter #(
      .CH(CH), .TW(TW), .RISE_TIME(RISE), .FALL_TIME(FALL), .INIT(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .sin(sin), .timer_600n(timer_600n), .cnt_clr(cnt_clr),
      .sout(sout), .glitch(glitch), .busy(busy), .glitch_cnt(glitch_cnt)
   );

   typedef struct {
      int kind;   // 0 = sout change, 1 = glitch pulse
      int ch;
      int val;
      int edg;
   } ev_t;

   ev_t           sbq[$];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   bit            mon_en = 1'b0;
   logic [CH-1:0] prev_sout = '0;
   logic [CH-1:0] cur = '0;
   int            bs = 0;
   int            be = 0;
   int            clr_at = -1;
   int            mcnt[CH];

   // Timer value seen during the cycle that follows clock edge n.
   function automatic logic [TW-1:0] tmr(input int n);
      return TW'((n / STEP + OFF) % 256);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic take_event(input int kind, input int ch, input int val);
      ev_t e;
      if (sbq.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event actual=kind%0d/ch%0d/val%0d required=none cycle=%0d", kind, ch, val, cyc);
      end else begin
         e = sbq.pop_front();
         $display("event %s ch=%0d val=%0d cycle=%0d", kind ? "glitch" : "sout", ch, val, cyc);
         check("event_kind", kind, e.kind);
         check("event_ch", ch, e.ch);
         check("event_val", val, e.val);
         check("event_cycle", cyc, e.edg);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int c = 0; c < CH; c++) begin
            if (glitch[c] === 1'b1) take_event(1, c, 1);
            if (sout[c] !== prev_sout[c]) take_event(0, c, int'(sout[c]));
         end
         prev_sout = sout;
         check("busy", busy, (cyc >= bs && cyc < be) ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      timer_600n = tmr(cyc);
      cnt_clr    = (cyc == clr_at);
   endtask

   task automatic chk_cnt();
      for (int c = 0; c < CH; c++) check("glitch_cnt", glitch_cnt[8*c +: 8], mcnt[c]);
   endtask

   // mode 0: random length, 1: return on the exact match cycle, 2: hold, 3: fixed length lfix
   task automatic xact(input int ch, input int mode, input int lfix, input bit do_clr);
      int a, n, L, tg, thr;
      logic newl;
      bit gl;
      newl = ~cur[ch];
      tick();
      a = cyc;
      sin[ch] = newl;
      tg = (int'(tmr(a + 2)) + (newl ? RISE : FALL)) % 256;
      n = a + 3;
      while (int'(tmr(n)) != tg && n < a + 3 + STEP * 260) n++;
      thr = n - 2 - a;
      case (mode)
         0:       L = $urandom_range(1, thr + 42);
         1:       L = thr;
         2:       L = thr + 1;
         default: L = lfix;
      endcase
      gl = (L <= thr) && (mode != 2);
      bs = a + 3;
      if (gl) begin
         be = a + L + 3;
         sbq.push_back('{1, ch, 1, be});
         if (do_clr) begin
            clr_at = a + L + 2;
            for (int c = 0; c < CH; c++) mcnt[c] = 0;
         end else begin
`ifdef MULTI_SIGNAL_FILTER_GLITCH_CNT_EN
            if (mcnt[ch] < 255) mcnt[ch]++;
`endif
         end
         while (cyc < a + L) tick();
         sin[ch] = cur[ch];
      end else begin
         be = n + 1;
         sbq.push_back('{0, ch, int'(newl), be});
         cur[ch] = newl;
      end
      while (cyc < be + 8) tick();
      clr_at = -1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      for (int c = 0; c < CH; c++) mcnt[c] = 0;
      timer_600n = tmr(0);
      repeat (3) tick();
      check("rst_sout", sout, 0);
      check("rst_glitch", glitch, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", glitch_cnt, 0);
      rst = 1'b1;
      prev_sout = sout;
      mon_en = 1'b1;

      // Edge at timer 100 with a 200-tick rise target wraps to 44.
      while (tmr(cyc + 3) != 8'd100) tick();
      xact(0, 2, 0, 1'b0);

      // 50-tick high pulse on a low input is rejected.
      xact(1, 3, 50 * STEP, 1'b0);
      chk_cnt();

      // Asymmetric: raise ch2, then a 100-tick low pulse qualifies against FALL=60.
      xact(2, 2, 0, 1'b0);
      xact(2, 3, 100 * STEP, 1'b0);

      for (int i = 0; i < 20; i++) xact($urandom_range(0, CH - 1), (i % 5 == 4) ? 1 : 0, 0, 1'b0);
      chk_cnt();

      // Return edge coincident with the timer match on each channel.
      for (int c = 0; c < CH; c++) xact(c, 1, 0, 1'b0);
      chk_cnt();

      // Saturation on ch3.
      for (int i = 0; i < 260; i++) xact(3, 3, $urandom_range(1, 6), 1'b0);
      chk_cnt();

      // Clear on the same edge as a glitch increment.
      xact(2, 3, 3, 1'b1);
      chk_cnt();
      xact(1, 3, 5, 1'b0);
      chk_cnt();

      // Reset while a fall is pending on ch0.
      if (cur[0] == 1'b0) xact(0, 2, 0, 1'b0);
      tick();
      a = cyc;
      sin = '0;
      for (int c = 1; c < CH; c++) if (cur[c]) begin
         bs = 0;
      end
      bs = a + 3;
      be = a + 100000;
      while (cyc < a + 20) tick();
      check("busy_pre_rst", busy, 1);
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst_sout", sout, 0);
      check("midrst_glitch", glitch, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cnt", glitch_cnt, 0);
      repeat (3) tick();
      rst = 1'b1;
      cur = '0;
      bs = 0;
      be = 0;
      for (int c = 0; c < CH; c++) mcnt[c] = 0;
      prev_sout = sout;
      mon_en = 1'b1;
      repeat (1200) tick();
      chk_cnt();
      check("sout_after_rst", sout, 0);

      check("scoreboard_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
